// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage. Holds the pipeline
// via md_stall while a 32-cycle shift-add multiply or restoring divide runs.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_start,
  input  logic [2:0]      ex_md_op,
  input  logic [XLEN-1:0] ex_aluA,
  input  logic [XLEN-1:0] ex_aluB,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic              neg_res;
  logic              neg_rem;

  // Operand preparation for the incoming instruction (only used in IDLE)
  logic            in_signed, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  always_comb begin
    in_signed   = (ex_md_op == 3'b001) || (ex_md_op == 3'b100) || (ex_md_op == 3'b110);
    a_neg       = in_signed & ex_aluA[XLEN-1];
    b_neg       = in_signed & ex_aluB[XLEN-1];
    abs_a       = a_neg ? -ex_aluA : ex_aluA;
    abs_b       = b_neg ? -ex_aluB : ex_aluB;
    div_zero    = ex_md_op[2] && (ex_aluB == '0);
    div_ovf     = ((ex_md_op == 3'b100) || (ex_md_op == 3'b110)) &&
                  (ex_aluA == {1'b1, {(XLEN-1){1'b0}}}) && (ex_aluB == '1);
    special     = div_zero | div_ovf;
    if (div_zero) special_res = ex_md_op[1] ? ex_aluA : '1;
    else          special_res = ex_md_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration: acc high half is the partial product / remainder,
  // low half the multiplier / dividend shifting out as quotient shifts in.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   new_rem;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge       = rem_sh >= {1'b0, opb};
    new_rem  = ge ? XLEN'(rem_sh - {1'b0, opb}) : rem_sh[XLEN-1:0];
    div_next = {new_rem, acc[XLEN-2:0], ge};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      3'b001, 3'b010: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_res = quo;
      3'b110, 3'b111: fix_res = rem;
      default:        fix_res = prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      op        <= '0;
      opb       <= '0;
      acc       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      md_done   <= 1'b0;
      md_result <= '0;
    end else if (flush) begin
      state     <= IDLE;
      count     <= '0;
      md_done   <= 1'b0;
      md_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          md_done <= 1'b0;
          if (ex_start) begin
            op      <= ex_md_op;
            opb     <= abs_b;
            acc     <= {{XLEN{1'b0}}, abs_a};
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            count   <= '0;
            if (special) begin
              md_result <= special_res;
              md_done   <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= op[2] ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          md_result <= fix_res;
          md_done   <= 1'b1;
          state     <= DONE;
        end
        default: begin
          md_done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign md_stall = rst_n & (((state == IDLE) & ex_start) | (state == CALC) | (state == FIX));

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed results, cycle-exact done/stall
// timing, special cases, flush and asynchronous reset aborts.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ex_start = 1'b0;
  logic [2:0]  ex_md_op = 3'b000;
  logic [31:0] ex_aluA = '0;
  logic [31:0] ex_aluB = '0;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;

  ex_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .ex_start  (ex_start),
    .ex_md_op  (ex_md_op),
    .ex_aluA   (ex_aluA),
    .ex_aluB   (ex_aluB),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result)
  );

  // Clock / reset / cycle stamp
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int n_asserts = 0;
  int n_fail = 0;
  int last_start = 0;
  int last_done = 0;
  logic [31:0] exp_q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    ex_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Starts an op at the next negedge (cycle 0) and follows it to md_done.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_cyc, input bit perturb);
    int          done_c;
    int          stall_hi;
    logic        stall_at_done;
    logic [31:0] res;
    logic [31:0] exp;
    done_c = -1;
    stall_hi = 0;
    stall_at_done = 1'bx;
    res = 'x;
    exp_q.push_back(exp_res);
    @(negedge clk);
    ex_start = 1'b1;
    ex_md_op = op;
    ex_aluA  = a;
    ex_aluB  = b;
    last_start = cyc_cnt;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (md_done) begin
        done_c = c;
        res = md_result;
        stall_at_done = md_stall;
        break;
      end
      if (md_stall) stall_hi++;
      if (perturb && c == 5) begin
        ex_aluA = 32'h5555_5555;
        ex_aluB = 32'h0000_0003;
      end
      @(negedge clk);
    end
    last_done = cyc_cnt;
    exp = exp_q.pop_front();
    check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_cyc));
    check({tag, "_stall_cycles"}, 32'(stall_hi), 32'(exp_cyc));
    check({tag, "_stall_at_done"}, {31'd0, stall_at_done}, 32'd0);
    check({tag, "_result"}, res, exp);
  endtask

  initial begin
    int t0;
    int pulses;

    // Reset behaviour
    repeat (2) @(negedge clk);
    ex_start = 1'b1;
    #1;
    check("rst_stall_forced", {31'd0, md_stall}, 32'd0);
    check("rst_done", {31'd0, md_done}, 32'd0);
    check("rst_result", md_result, 32'd0);
    ex_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", {31'd0, md_stall}, 32'd0);
    check("post_rst_result", md_result, 32'd0);

    // Multiply
    run_op("mul_7xm3",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    idle(1);
    run_op("mulhu_max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    idle(1);
    run_op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);
    idle(1);
    run_op("mulh_m2x3",   3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34, 1'b0);
    idle(1);
    run_op("mul_rsvd",    3'b011, 32'd6,         32'd7,         32'd42,        34, 1'b0);
    idle(1);

    // Divide / remainder
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0);
    idle(1);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
    idle(1);
    run_op("divu_100_7",  3'b101, 32'd100,       32'd7,         32'd14,        34, 1'b0);
    idle(1);
    run_op("remu_100_7",  3'b111, 32'd100,       32'd7,         32'd2,         34, 1'b0);
    idle(1);
    run_op("div_20_m3",   3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 1'b0);
    idle(1);
    run_op("rem_20_m3",   3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         34, 1'b0);
    idle(1);

    // Special cases finish in cycle 1
    run_op("divu_by0",    3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1, 1'b0);
    idle(1);
    run_op("rem_by0",     3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 1, 1'b0);
    idle(1);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    idle(1);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);
    idle(1);
    run_op("remu_by0",    3'b111, 32'h0000_0055, 32'd0,         32'h0000_0055, 1, 1'b0);
    idle(1);

    // Flush in cycle 10 of a DIV
    ex_start = 1'b1;
    ex_md_op = 3'b100;
    ex_aluA  = 32'd1000;
    ex_aluB  = 32'd3;
    repeat (10) @(negedge clk);
    flush    = 1'b1;
    ex_start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall", {31'd0, md_stall}, 32'd0);
    check("flush_result", md_result, 32'd0);
    check("flush_done", {31'd0, md_done}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md_done) pulses++;
    end
    check("flush_no_done", 32'(pulses), 32'd0);
    run_op("mul_after_flush", 3'b000, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 34, 1'b0);
    idle(1);

    // Asynchronous reset in cycle 20 of a MUL
    ex_start = 1'b1;
    ex_md_op = 3'b000;
    ex_aluA  = 32'd9;
    ex_aluB  = 32'd9;
    repeat (20) @(negedge clk);
    #1;
    check("pre_rst_stall", {31'd0, md_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_stall", {31'd0, md_stall}, 32'd0);
    check("arst_done", {31'd0, md_done}, 32'd0);
    check("arst_result", md_result, 32'd0);
    ex_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md_done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);

    // Back-to-back MULs: second completes at cycle 69 of the first
    run_op("b2b_first",  3'b000, 32'd2, 32'd3, 32'd6,  34, 1'b0);
    t0 = last_start;
    run_op("b2b_second", 3'b000, 32'd4, 32'd5, 32'd20, 34, 1'b0);
    check("b2b_total_cycles", 32'(last_done - t0), 32'd69);
    ex_start = 1'b0;
    @(negedge clk);
    #1;
    check("done_one_pulse", {31'd0, md_done}, 32'd0);
    check("result_holds", md_result, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
